// File: rtl/weight_buf_pkg.sv
// Shared definitions for the ping-pong weight buffer: loader state encoding and checksum width.
// The optional load checksum is enabled by defining WEIGHT_BUF_CHECKSUM_EN.
package weight_buf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    localparam int CHECKSUM_WIDTH = 16;

endpackage

// File: rtl/weight_bank.sv
// One weight bank: NR_DEPTH filters x NR_FEATURE words, a single word-write port and a
// registered read port that returns every lane of one filter per cycle.
module weight_bank #(
    parameter int BIT_WIDTH            = 8,
    parameter int NR_DEPTH             = 8,
    parameter int DEPTH_COUNTER_BITS   = 3,
    parameter int NR_FEATURE           = 6,
    parameter int FEATURE_COUNTER_BITS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [DEPTH_COUNTER_BITS-1:0]    wr_depth,
    input  logic [FEATURE_COUNTER_BITS-1:0]  wr_feature,
    input  logic [BIT_WIDTH-1:0]             wr_data,
    input  logic                             rd_en,
    input  logic [DEPTH_COUNTER_BITS-1:0]    rd_addr,
    output logic [NR_FEATURE*BIT_WIDTH-1:0]  rd_data
);

    // Arrays are indexed with exactly clog2(NR_DEPTH) bits; the counters may be wider.
    localparam int ADDR_BITS = (NR_DEPTH > 1) ? $clog2(NR_DEPTH) : 1;

    logic [ADDR_BITS-1:0] wr_index;
    logic [ADDR_BITS-1:0] rd_index;
    logic                 rd_in_range;

    assign wr_index    = wr_depth[ADDR_BITS-1:0];
    assign rd_index    = rd_addr[ADDR_BITS-1:0];
    assign rd_in_range = (32'(rd_addr) < 32'(NR_DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < NR_FEATURE; gi++) begin : g_lane
            logic [BIT_WIDTH-1:0] mem [NR_DEPTH];
            logic [BIT_WIDTH-1:0] lane_reg;

            // Storage carries no reset so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_feature == FEATURE_COUNTER_BITS'(gi))) begin
                    mem[wr_index] <= wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (rd_en) begin
                    lane_reg <= rd_in_range ? mem[rd_index] : '0;
                end
            end

            assign rd_data[gi*BIT_WIDTH +: BIT_WIDTH] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-banked filter-weight store: a valid/ready loader fills the shadow bank while the
// compute side reads whole filters from the active bank. Define WEIGHT_BUF_CHECKSUM_EN for load_checksum.
module weight_pingpong_buffer
    import weight_buf_pkg::*;
#(
    parameter int BIT_WIDTH            = 8,
    parameter int NR_DEPTH             = 8,
    parameter int DEPTH_COUNTER_BITS   = 3,
    parameter int NR_FEATURE           = 6,
    parameter int FEATURE_COUNTER_BITS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             load_valid,
    input  logic [BIT_WIDTH-1:0]             load_data,
    output logic                             load_ready,
    output logic                             load_done,
    output logic                             shadow_full,
    input  logic                             swap_req,
    output logic                             bank_sel,
    input  logic                             read_en,
    input  logic [DEPTH_COUNTER_BITS-1:0]    read_addr,
    output logic [NR_FEATURE*BIT_WIDTH-1:0]  read_data,
    output logic                             read_valid
`ifdef WEIGHT_BUF_CHECKSUM_EN
    ,
    output logic [CHECKSUM_WIDTH-1:0]        load_checksum
`endif
);

    localparam logic [FEATURE_COUNTER_BITS-1:0] FEATURE_LAST = FEATURE_COUNTER_BITS'(NR_FEATURE - 1);
    localparam logic [DEPTH_COUNTER_BITS-1:0]   DEPTH_LAST   = DEPTH_COUNTER_BITS'(NR_DEPTH - 1);

    logic [1:0]                      state_reg, state_next;
    logic [FEATURE_COUNTER_BITS-1:0] feature_reg, feature_next;
    logic [DEPTH_COUNTER_BITS-1:0]   depth_reg, depth_next;
    logic                            bank_sel_reg, bank_sel_next;
    logic                            load_done_reg, load_done_next;
    logic                            read_valid_reg;
    logic                            read_sel_reg;
    logic                            accept;
    logic                            restart;
    logic                            last_word;

    logic [NR_FEATURE*BIT_WIDTH-1:0] bank_rd_data [2];

    assign load_ready  = (state_reg == ST_LOAD);
    assign shadow_full = (state_reg == ST_FULL);
    assign bank_sel    = bank_sel_reg;
    assign load_done   = load_done_reg;
    assign read_valid  = read_valid_reg;

    // A restart in LOAD takes priority over a word offered in the same cycle; that word is dropped.
    assign accept    = load_ready && load_valid && !load_start;
    assign restart   = load_start && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD) ||
                                      ((state_reg == ST_FULL) && swap_req));
    assign last_word = (feature_reg == FEATURE_LAST) && (depth_reg == DEPTH_LAST);

    always_comb begin
        state_next     = state_reg;
        feature_next   = feature_reg;
        depth_next     = depth_reg;
        bank_sel_next  = bank_sel_reg;
        load_done_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && last_word) begin
                    state_next     = ST_FULL;
                    load_done_next = 1'b1;
                end
            end
            ST_FULL: begin
                if (swap_req) begin
                    bank_sel_next = ~bank_sel_reg;
                    state_next    = load_start ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (restart) begin
            feature_next = '0;
            depth_next   = '0;
        end else if (accept) begin
            if (feature_reg == FEATURE_LAST) begin
                feature_next = '0;
                depth_next   = depth_reg + 1'b1;
            end else begin
                feature_next = feature_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            feature_reg    <= '0;
            depth_reg      <= '0;
            bank_sel_reg   <= 1'b0;
            load_done_reg  <= 1'b0;
            read_valid_reg <= 1'b0;
            read_sel_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            feature_reg    <= feature_next;
            depth_reg      <= depth_next;
            bank_sel_reg   <= bank_sel_next;
            load_done_reg  <= load_done_next;
            read_valid_reg <= read_en;
            // Remember which bank answered so read_data holds across idle cycles and swaps.
            if (read_en) begin
                read_sel_reg <= bank_sel_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic bank_wr_en;
            logic bank_rd_en;

            assign bank_wr_en = accept && (bank_sel_reg != 1'(gi));
            assign bank_rd_en = read_en && (bank_sel_reg == 1'(gi));

            weight_bank #(
                .BIT_WIDTH            (BIT_WIDTH),
                .NR_DEPTH             (NR_DEPTH),
                .DEPTH_COUNTER_BITS   (DEPTH_COUNTER_BITS),
                .NR_FEATURE           (NR_FEATURE),
                .FEATURE_COUNTER_BITS (FEATURE_COUNTER_BITS)
            ) u_bank (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_en      (bank_wr_en),
                .wr_depth   (depth_reg),
                .wr_feature (feature_reg),
                .wr_data    (load_data),
                .rd_en      (bank_rd_en),
                .rd_addr    (read_addr),
                .rd_data    (bank_rd_data[gi])
            );
        end
    endgenerate

    assign read_data = read_sel_reg ? bank_rd_data[1] : bank_rd_data[0];

`ifdef WEIGHT_BUF_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] checksum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (restart) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + CHECKSUM_WIDTH'(load_data);
        end
    end

    assign load_checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Scoreboard bench for weight_pingpong_buffer: a bank-level model predicts control outputs
// each cycle and queues expected read rows that a separate monitor pops on read_valid.
module tb_weight_pingpong_buffer;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        load_done;
    logic        shadow_full;
    logic        swap_req;
    logic        bank_sel;
    logic        read_en;
    logic [3:0]  read_addr;
    logic [47:0] read_data;
    logic        read_valid;
`ifdef WEIGHT_BUF_CHECKSUM_EN
    logic [15:0] load_checksum;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: bank contents, active bank, loader progress.
    logic [7:0]  bank_m [2][8][6];
    bit          m_sel;
    bit          m_loading;
    bit          m_full;
    bit          m_done;
    int          m_cnt;
    logic [15:0] m_sum;
    logic [47:0] exp_q [$];

    weight_pingpong_buffer #(
        .BIT_WIDTH            (8),
        .NR_DEPTH             (8),
        .DEPTH_COUNTER_BITS   (4),
        .NR_FEATURE           (6),
        .FEATURE_COUNTER_BITS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .shadow_full (shadow_full),
        .swap_req    (swap_req),
        .bank_sel    (bank_sel),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .read_valid  (read_valid)
`ifdef WEIGHT_BUF_CHECKSUM_EN
        ,
        .load_checksum (load_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] expect_row(input int b, input int a);
        logic [47:0] r;
        r = '0;
        if (a < 8) begin
            for (int f = 0; f < 6; f++) r[f*8 +: 8] = bank_m[b][a][f];
        end
        return r;
    endfunction

    // Monitor: every presented read is compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && read_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected t=%0t data=%h with no pending read", $time, read_data);
            end else begin
                logic [47:0] want;
                want = exp_q.pop_front();
                if (read_data !== want) begin
                    errors++;
                    $display("FAIL read_data t=%0t got=%h want=%h", $time, read_data, want);
                end else begin
                    $display("read ok t=%0t data=%h", $time, read_data);
                end
            end
        end
    end

    task automatic step(input logic ls, input logic lv, input logic [7:0] ld,
                        input logic sr, input logic re, input logic [3:0] ra);
        logic [4:0] got, want;
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        swap_req   = sr;
        read_en    = re;
        read_addr  = ra;
        if (re) exp_q.push_back(expect_row(int'(m_sel), int'(ra)));
        m_done = 1'b0;
        if (m_loading) begin
            if (ls) begin
                m_cnt = 0;
                m_sum = '0;
            end else if (lv) begin
                bank_m[int'(!m_sel)][m_cnt / 6][m_cnt % 6] = ld;
                m_sum = m_sum + 16'(ld);
                m_cnt++;
                if (m_cnt == 48) begin
                    m_loading = 1'b0;
                    m_full    = 1'b1;
                    m_done    = 1'b1;
                end
            end
        end else if (m_full) begin
            if (sr) begin
                m_sel  = !m_sel;
                m_full = 1'b0;
                if (ls) begin
                    m_loading = 1'b1;
                    m_cnt     = 0;
                    m_sum     = '0;
                end
            end
        end else if (ls) begin
            m_loading = 1'b1;
            m_cnt     = 0;
            m_sum     = '0;
        end
        @(posedge clk);
        #1;
        want = {m_loading, m_full, m_sel, m_done, re};
        got  = {load_ready, shadow_full, bank_sel, load_done, read_valid};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL ctrl t=%0t ready/full/sel/done/rvalid got=%b want=%b", $time, got, want);
        end
`ifdef WEIGHT_BUF_CHECKSUM_EN
        if (m_full) begin
            checks++;
            if (load_checksum !== m_sum) begin
                errors++;
                $display("FAIL checksum t=%0t got=%h want=%h", $time, load_checksum, m_sum);
            end
        end
`endif
    endtask

    // mode 0: data = index+1, valid held; 1: fixed data; 2: valid toggling, random data;
    // 3: random valid, random data, stray swap requests.
    task automatic run_load(input int mode, input logic [7:0] fixed, input bit reads, input bit do_start);
        int c;
        logic lv, sr, re;
        logic [7:0] d;
        if (do_start) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        for (c = 0; c < 400 && !m_full; c++) begin
            lv = (mode == 2) ? c[0] : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = (mode == 0) ? 8'(m_cnt + 1) : (mode == 1) ? fixed : 8'($urandom);
            sr = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            re = reads ? 1'($urandom_range(0, 1)) : 1'b0;
            step(1'b0, lv, d, sr, re, 4'($urandom_range(0, 7)));
        end
        checks++;
        if (!m_full || !shadow_full) begin
            errors++;
            $display("FAIL load_timeout mode=%0d accepted=%0d shadow_full=%b want 48 and 1", mode, m_cnt, shadow_full);
        end else begin
            $display("load mode=%0d done accepted=%0d", mode, m_cnt);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        if ({load_ready, shadow_full, bank_sel, load_done, read_valid} !== 5'b0 || read_data !== '0) begin
            errors++;
            $display("FAIL %s got ctrl=%b data=%h want ctrl=00000 data=0", tag,
                     {load_ready, shadow_full, bank_sel, load_done, read_valid}, read_data);
        end
`ifdef WEIGHT_BUF_CHECKSUM_EN
        checks++;
        if (load_checksum !== 16'h0) begin
            errors++;
            $display("FAIL %s_checksum got=%h want=0", tag, load_checksum);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_data = 0; swap_req = 0; read_en = 0; read_addr = 0;
        m_sel = 0; m_loading = 0; m_full = 0; m_done = 0; m_cnt = 0; m_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Words 1..48 into bank 1, then swap and read filter 2 (lanes 13..18).
        run_load(0, 8'h00, 1'b0, 1'b1);
`ifdef WEIGHT_BUF_CHECKSUM_EN
        checks++;
        if (load_checksum !== 16'd1176) begin
            errors++;
            $display("FAIL checksum_1176 got=%0d want=1176", load_checksum);
        end
`endif
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);

        // 0xFF into bank 0 while bank 1 is read; then swap with a read in the swap cycle.
        run_load(1, 8'hFF, 1'b1, 1'b1);
`ifdef WEIGHT_BUF_CHECKSUM_EN
        checks++;
        if (load_checksum !== 16'h2FD0) begin
            errors++;
            $display("FAIL checksum_2fd0 got=%h want=2fd0", load_checksum);
        end
`endif
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd3);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3);

        // Toggling valid, start alone in FULL, swap+start, random-valid load.
        run_load(2, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 4'd5);
        run_load(3, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd1);

        // Out-of-range addresses, swap ignored in IDLE.
        for (int a = 8; a < 16; a++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'(a));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd9);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4);

        // Reset after 20 accepted words.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        for (int c = 0; c < 100 && m_cnt < 20; c++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 4'($urandom_range(0, 7)));
        rst_n = 1'b0;
        #2;
        check_reset("midload_reset");
        exp_q.delete();
        m_sel = 0; m_loading = 0; m_full = 0; m_cnt = 0; m_sum = '0;
        load_valid = 1'b0;
        read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd6);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads got=%0d outstanding want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_pingpong_buffer.md
# weight_pingpong_buffer

Double-banked filter-weight store for the convolution datapath, generalised to any lane count. A streaming loader fills the shadow bank word by word with a valid/ready handshake. The compute side reads one filter (all feature lanes) per cycle from the active bank. A swap request exchanges the banks, so the next layer's weights load while the current layer computes.

## Interface
- Bit_width, 8: bits per weight/bias word
- Nr_depth, 8: filters per bank (need not be a power of 2)
- Depth_counter_bits, 3: 2**value >= Nr_depth
- Nr_feature, 6: weights + bias per filter; equals the number of read lanes
- Feature_counter_bits, 3: 2**value >= Nr_feature
- Clk  in  1  clock; all registers update on the rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Load_start  in  1  begin filling the shadow bank from word 0
- Load_valid  in  1  Load_data is valid
- Load_data  in  Bit_width  weight word; order is filter-major, feature-minor
- Load_ready  out  1  loader accepts a word this cycle
- Load_done  out  1  one-cycle pulse after the last word is accepted
- Shadow_full  out  1  shadow bank is complete and not yet swapped
- Swap_req  in  1  make the shadow bank active
- Bank_sel  out  1  index of the active bank
- Read_en  in  1  read request
- Read_addr  in  Depth_counter_bits  filter index
- Read_data  out  Nr_feature*Bit_width  lane f is bits [f*Bit_width +: Bit_width]
- Read_valid  out  1  Read_data is updated this cycle
- Load_checksum  out  16  present only with WEIGHT_BUF_CHECKSUM_EN

## Operation
- Loader FSM has three states: IDLE, LOAD, FULL.
- IDLE: Load_ready=0. Load_start moves to LOAD and clears the feature and depth counters.
- LOAD: Load_ready=1.
  - A word is accepted when Load_valid && Load_ready. It is written to shadow[depth][feature].
  - The feature counter wraps at Nr_feature-1 and increments the depth counter.
  - The word at depth Nr_depth-1, feature Nr_feature-1 moves to FULL and pulses Load_done.
  - Load_start while in LOAD aborts the fill: counters return to 0 and the state stays LOAD. Partial shadow contents are overwritten.
- FULL: Shadow_full=1, Load_ready=0.
  - Swap_req toggles Bank_sel and moves to IDLE.
  - Swap_req together with Load_start toggles Bank_sel and moves directly to LOAD, filling the old active bank.
- Swap_req is ignored in IDLE and LOAD. Load_start alone is ignored in FULL.
- Read path: when Read_en=1, Read_data <= active[Read_addr] (all lanes).
  - Read_addr >= Nr_depth returns all zeros.
  - When Read_en=0, Read_data holds its previous value.
- Simultaneous read and swap: the read uses the pre-swap Bank_sel.
- Loader writes never touch the active bank, so there is no read/write collision.

## Timing
- Reset values: Bank_sel=0, state=IDLE, Load_ready=0, Load_done=0, Shadow_full=0, Read_valid=0, Read_data=0, Load_checksum=0.
- RAM contents are not reset. Reset mid-load abandons the fill, and the shadow contents are undefined.
- Read latency is 1 cycle. Read_valid is Read_en registered.
- Load_ready rises the cycle after Load_start.
- Load throughput is 1 word per cycle; a full bank takes Nr_depth*Nr_feature accepted words.
- Load_done and Shadow_full assert the cycle after the last accept.
- Bank_sel and Shadow_full change the cycle after Swap_req.
- Reads issued in the swap cycle return the old bank. Reads one cycle later return the new bank.

## Configuration
- WEIGHT_BUF_CHECKSUM_EN defined:
  - Load_checksum is a 16-bit modulo-2^16 sum of the zero-extended accepted words.
  - It is cleared on any accepted Load_start and is stable while in FULL.
- Macro undefined: the port and its adder are absent; all other behaviour is identical.

## Structure
- Shared package weight_buf_pkg holds:
  - the loader state encoding (IDLE=2'd0, LOAD=2'd1, FULL=2'd2)
  - the checksum width constant (16)
- Sub-module weight_bank holds one bank: Nr_depth x Nr_feature words, one word-write port, one registered wide read port.
- weight_bank is instantiated twice. Top-level muxes route writes by ~Bank_sel and reads by Bank_sel.

## Test plan
- Reset, then Load_start, then words 1..48 with Load_valid held high. Required: Load_done pulses once after word 48, Shadow_full=1, Bank_sel=0, Load_checksum=1176.
- Swap_req, then read addr 2. Required: Bank_sel=1 one cycle after the swap; Read_data lanes are 13..18 (lane 0 = 13) with Read_valid one cycle after Read_en.
- Load bank 0 with 48 words of 0xFF while reading bank 1 every cycle. Required: reads stay unchanged, and Load_checksum=0x2FD0 at FULL.
- Load_valid toggling at a 50% duty cycle. Required: exactly 48 accepts and Load_done after the 48th accept.
- Read_addr=9 with Nr_depth=8. Required: zero data, Read_valid=1. Swap_req in IDLE: no Bank_sel change.
- Rst_n low after word 20 of a load. Required: all outputs at reset values immediately, Bank_sel=0, state IDLE.
